dom1_skinny_ctrl: RTL and testbench
===================================

Name: dom1_skinny_ctrl

Overview:
- Sequencer for the first-order DOM-protected Skinny-128-384+ round datapath.
- Drives the four sbox-stage enables one stage per cycle and gates them on fresh-randomness availability.
- Generates the state-register and tweakey-schedule write strobes, the 6-bit round constant, and the round counter.
- Provides the start/busy/done handshake to the surrounding mode controller.

Parameters:
NUM_ROUNDS, 40, number of Skinny rounds per block; legal range 1..63.
RC_INIT, 6'h00, LFSR seed; the first round uses the first updated value.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a block; sampled only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; masked state shares are final
load  output  1  state register loads the input shares (first round only)
en  output  4  sbox stage enables, one-hot or zero
state_we  output  1  state register captures the round output shares
tk_upd  output  1  tweakey shares advance one schedule step
rc  output  6  round constant for the current round
round_cnt  output  6  index of the current round, 0..NUM_ROUNDS-1
last_rnd  output  1  round_cnt == NUM_ROUNDS-1
rnd_req  output  1  a 128-bit fresh mask is required this cycle
rnd_valid  input  1  fresh mask on r is valid; consumed when rnd_req & rnd_valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rc=RC_INIT, round_cnt=0. All strobes (load, en, state_we, tk_upd, done, rnd_req) and busy are 0.
- FSM states: IDLE, LOAD, S0, S1, S2, S3, UPD, FIN.
- IDLE: start=1 moves to LOAD and sets rc <= LFSR(RC_INIT), round_cnt <= 0.
- LOAD: load=1 for one cycle, then S0.
- Sk (k=0..3):
  - rnd_req=1 and en[k]=rnd_valid.
  - Advance to S(k+1), or from S3 to UPD, only when rnd_valid=1.
  - Otherwise hold, with en=0.
  - A stall at any stage freezes all pipeline registers; no enable is ever skipped or repeated.
- UPD: state_we=1 and tk_upd=1 for one cycle.
  - If last_rnd=1, go to FIN.
  - Else round_cnt+1, rc <= LFSR(rc), go to S0.
- FIN: done=1 for one cycle, go to IDLE. rc and round_cnt hold until the next start.
- LFSR(x) = {x[4:0], x[5]^x[4]^1}. From seed 0 the sequence is 01, 03, 07, 0F, 1F, 3E, 3D, 3B, ...
- en and state_we are never high in the same cycle. S0 samples the state register, so the write must precede it.
- Latency with no stalls: 1 (LOAD) + 5*NUM_ROUNDS + 1 (FIN). For NUM_ROUNDS=40, done is high exactly 202 cycles after the cycle in which start was sampled.
- Each stall cycle adds exactly one cycle to that latency.
- start while busy is ignored; no queuing.
- start in the same cycle as done (FIN) is ignored. start is accepted from the next IDLE cycle.
- rnd_valid outside S0..S3 is ignored and does not count as consumed.
- rst_n asserted mid-block aborts immediately to the reset state; no done pulse is produced.
- NUM_ROUNDS=1: LOAD, S0..S3, UPD, FIN; last_rnd is high throughout.

Test Plan:
- Reset: hold rst_n=0 with start=1 and rnd_valid=1 -> all outputs 0, rc=00, state stays IDLE; release -> still idle until start.
- Full block, rnd_valid tied 1, start pulse at cycle 0:
  - load at cycle 1; en=0001, 0010, 0100, 1000 at cycles 2..5; state_we=tk_upd=1 at cycle 6.
  - 40 state_we pulses in total; done at cycle 202.
- Round constants: capture rc at each state_we -> 01, 03, 07, 0F, 1F, 3E, 3D, 3B, 37, 2F, ... ending 1A at round 39; round_cnt 0..39; last_rnd high only in round 39.
- Randomness stall: drop rnd_valid for 3 cycles while in S2 of round 5:
  - en=0 and rnd_req=1 throughout the stall; en[2] fires once on recovery.
  - done arrives at cycle 205; exactly 160 accepted masks per block.
- start while busy at cycle 50 and in the FIN cycle -> ignored, single done; start at cycle 203 -> new block, load at 204.
- rst_n pulsed low at cycle 100 -> outputs 0 in the same cycle (asynchronous); no done; a following start runs a clean 202-cycle block with rc restarting at 01.

Source files
------------

// File: rtl/dom1_skinny_ctrl.sv
// dom1_skinny_ctrl
// Sequencer for the first-order DOM-protected Skinny-128-384+ round datapath.
// Each round walks through four sbox stages (one enable per cycle, each one
// consuming a fresh 128-bit mask) followed by one update cycle that writes the
// state register and advances the tweakey schedule.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a block (sampled only while idle)
//   busy       high whenever a block is in progress
//   done       one-cycle pulse, state shares are final
//   load       state register loads the input shares
//   en[3:0]    sbox stage enables, one-hot or zero
//   state_we   state register captures the round output shares
//   tk_upd     tweakey shares advance one schedule step
//   rc[5:0]    round constant of the current round
//   round_cnt  index of the current round
//   last_rnd   current round is the final one
//   rnd_req    a fresh mask is required this cycle
//   rnd_valid  fresh mask is valid (consumed when rnd_req & rnd_valid)
module dom1_skinny_ctrl #(
    parameter int          NUM_ROUNDS = 40,
    parameter logic [5:0]  RC_INIT    = 6'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       load,
    output logic [3:0] en,
    output logic       state_we,
    output logic       tk_upd,
    output logic [5:0] rc,
    output logic [5:0] round_cnt,
    output logic       last_rnd,
    output logic       rnd_req,
    input  logic       rnd_valid
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_S0   = 3'd2,
        ST_S1   = 3'd3,
        ST_S2   = 3'd4,
        ST_S3   = 3'd5,
        ST_UPD  = 3'd6,
        ST_FIN  = 3'd7
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

    // Round-constant LFSR step: shift left, feed back x5 ^ x4 ^ 1.
    function automatic logic [5:0] lfsr_next(input logic [5:0] x);
        return {x[4:0], x[5] ^ x[4] ^ 1'b1};
    endfunction

    state_t      state_r;
    logic [5:0]  rc_r;
    logic [5:0]  round_cnt_r;
    logic        last_rnd_r;
    logic        busy_r;
    logic        load_r;
    logic        upd_r;
    logic        done_r;
    logic        req_r;
    logic [1:0]  stage_r;
    logic [3:0]  en_s;

    // Sequencer FSM with all strobes registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rc_r        <= RC_INIT;
            round_cnt_r <= 6'd0;
            last_rnd_r  <= 1'b0;
            busy_r      <= 1'b0;
            load_r      <= 1'b0;
            upd_r       <= 1'b0;
            done_r      <= 1'b0;
            req_r       <= 1'b0;
            stage_r     <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r     <= ST_LOAD;
                        rc_r        <= lfsr_next(RC_INIT);
                        round_cnt_r <= 6'd0;
                        last_rnd_r  <= (LAST_IDX == 6'd0);
                        busy_r      <= 1'b1;
                        load_r      <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_S0;
                    load_r  <= 1'b0;
                    req_r   <= 1'b1;
                    stage_r <= 2'd0;
                end
                // A missing mask simply holds the stage: nothing else moves,
                // so every enable fires exactly once per round.
                ST_S0, ST_S1, ST_S2: begin
                    if (rnd_valid) begin
                        state_r <= state_t'(state_r + 3'd1);
                        stage_r <= stage_r + 2'd1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_S3: begin
                    if (rnd_valid) begin
                        state_r <= ST_UPD;
                        req_r   <= 1'b0;
                        upd_r   <= 1'b1;
                    end else begin
                        state_r <= ST_S3;
                    end
                end
                // The write lands here, one cycle before S0 samples the state.
                ST_UPD: begin
                    upd_r <= 1'b0;
                    if (last_rnd_r) begin
                        state_r <= ST_FIN;
                        done_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_S0;
                        round_cnt_r <= round_cnt_r + 6'd1;
                        last_rnd_r  <= ((round_cnt_r + 6'd1) == LAST_IDX);
                        rc_r        <= lfsr_next(rc_r);
                        req_r       <= 1'b1;
                        stage_r     <= 2'd0;
                    end
                end
                // rc and round_cnt keep their final values until the next start.
                ST_FIN: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    load_r  <= 1'b0;
                    upd_r   <= 1'b0;
                    done_r  <= 1'b0;
                    req_r   <= 1'b0;
                    stage_r <= 2'd0;
                end
            endcase
        end
    end

    // Stage enable follows the mask handshake within the same cycle.
    always_comb begin
        en_s = 4'b0000;
        if (req_r && rnd_valid) begin
            case (stage_r)
                2'd0:    en_s = 4'b0001;
                2'd1:    en_s = 4'b0010;
                2'd2:    en_s = 4'b0100;
                2'd3:    en_s = 4'b1000;
                default: en_s = 4'b0000;
            endcase
        end else begin
            en_s = 4'b0000;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign load      = load_r;
    assign en        = en_s;
    assign state_we  = upd_r;
    assign tk_upd    = upd_r;
    assign rc        = rc_r;
    assign round_cnt = round_cnt_r;
    assign last_rnd  = last_rnd_r;
    assign rnd_req   = req_r;

endmodule

// File: tb/tb_dom1_skinny_ctrl.sv
// Self-checking bench for dom1_skinny_ctrl. A behavioural model tracks block
// progress as a single position counter (LOAD, then five steps per round,
// then FIN) and derives every expected output arithmetically from it.
module tb_dom1_skinny_ctrl;

    localparam int         N    = 40;
    localparam logic [5:0] SEED = 6'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rnd_valid = 1'b0;
    logic       busy, done, load, state_we, tk_upd, last_rnd, rnd_req;
    logic [3:0] en;
    logic [5:0] rc, round_cnt;

    dom1_skinny_ctrl #(.NUM_ROUNDS(N), .RC_INIT(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .load(load), .en(en), .state_we(state_we), .tk_upd(tk_upd), .rc(rc),
        .round_cnt(round_cnt), .last_rnd(last_rnd), .rnd_req(rnd_req),
        .rnd_valid(rnd_valid)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // per-block statistics gathered by the monitor
    int         we_cnt, mask_cnt, stall_cnt, done_cnt, en2_cnt;
    logic [5:0] rc_cap [0:63];

    // model state
    bit m_act = 1'b0;
    int m_p = 0;
    int m_hold = 0;
    bit m_started = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] rc_after(input int k);
        logic [5:0] x;
        x = SEED;
        for (int i = 0; i < k; i++) x = {x[4:0], x[5] ^ x[4] ^ 1'b1};
        return x;
    endfunction

    function automatic bit is_sbox(input int p);
        return (p >= 1) && (p <= 5 * N) && (((p - 1) % 5) < 4);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Model: advance block position on each clock; async reset clears it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0; m_p <= 0; m_hold <= 0; m_started <= 1'b0;
        end else if (!m_act) begin
            if (start) begin
                m_act <= 1'b1; m_p <= 0; m_started <= 1'b1;
            end
        end else if (m_p == 5 * N + 1) begin
            m_act <= 1'b0; m_hold <= N - 1;
        end else if (is_sbox(m_p)) begin
            if (rnd_valid) m_p <= m_p + 1;
        end else begin
            m_p <= m_p + 1;
        end
    end

    // Compare process: every output against the model on every falling edge.
    always @(negedge clk) begin
        int r, ph;
        bit mid, req;
        logic [3:0] e_en;
        mid = m_act && (m_p >= 1) && (m_p <= 5 * N);
        ph  = mid ? (m_p - 1) % 5 : 0;
        if (m_act) r = (m_p == 0) ? 0 : (((m_p - 1) / 5 > N - 1) ? N - 1 : (m_p - 1) / 5);
        else       r = m_hold;
        req  = mid && (ph < 4);
        e_en = (req && rnd_valid) ? (4'b0001 << ph) : 4'b0000;
        chk("busy", busy, m_act);
        chk("load", load, m_act && m_p == 0);
        chk("rnd_req", rnd_req, req);
        chk("en", en, e_en);
        chk("state_we", state_we, mid && ph == 4);
        chk("tk_upd", tk_upd, mid && ph == 4);
        chk("done", done, m_act && m_p == 5 * N + 1);
        chk("round_cnt", round_cnt, r);
        chk("last_rnd", last_rnd, m_started && r == N - 1);
        chk("rc", rc, m_started ? rc_after(r + 1) : SEED);
        if (state_we) begin
            we_cnt++;
            rc_cap[round_cnt] = rc;
        end
        if (rnd_req && rnd_valid) mask_cnt++;
        if (rnd_req && !rnd_valid) stall_cnt++;
        if (en[2]) en2_cnt++;
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: rnd_valid tied high except a 3-cycle hole at stall_at; mode 1: random
    task automatic run_block(input int mode, input int stall_at, input int abort_at,
                             output int lat);
        int n;
        bit seen;
        we_cnt = 0; mask_cnt = 0; stall_cnt = 0; done_cnt = 0; en2_cnt = 0;
        lat = -1;
        seen = 1'b0;
        start = 1'b1;
        rnd_valid = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        chk("load_at_cycle1", load, 1);
        while (!seen && n < 1000) begin
            if (done) begin
                seen = 1'b1;
                lat = n;
            end
            start = (n == 50) || seen;
            if (mode == 1) rnd_valid = ($urandom_range(3) != 0);
            else           rnd_valid = !(n >= stall_at && n < stall_at + 3);
            if (n == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_en", en, 0);
                chk("abort_req", rnd_req, 0);
                chk("abort_rc", rc, 0);
                chk("abort_round", round_cnt, 0);
                start = 1'b0;
                tick(); tick();
                rst_n = 1'b1;
                return;
            end
            tick();
            n++;
        end
        start = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        // reset held with start and rnd_valid active
        rst_n = 1'b0; start = 1'b1; rnd_valid = 1'b1;
        repeat (4) tick();
        chk("rst_busy", busy, 0);
        chk("rst_rc", rc, 0);
        chk("rst_en", en, 0);
        rst_n = 1'b1; start = 1'b0;
        repeat (3) tick();
        chk("idle_after_rst", busy, 0);

        // clean block with ignored starts at cycle 50 and in FIN
        run_block(0, -1, -1, lat);
        chk("lat_clean", lat, 202);
        chk("we_count", we_cnt, 40);
        chk("mask_count", mask_cnt, 160);
        chk("en2_count", en2_cnt, 40);
        chk("done_count", done_cnt, 1);
        chk("rc_r0", rc_cap[0], 6'h01);
        chk("rc_r1", rc_cap[1], 6'h03);
        chk("rc_r5", rc_cap[5], 6'h3E);
        chk("rc_r9", rc_cap[9], 6'h2F);
        chk("rc_r39", rc_cap[39], 6'h1A);

        // immediately chained block (start at 203) with random mask availability
        run_block(1, -1, -1, lat);
        chk("lat_random", lat, 202 + stall_cnt);
        chk("mask_count_rand", mask_cnt, 160);
        chk("done_count_rand", done_cnt, 1);
        repeat (2) tick();

        // 3-cycle stall in S2 of round 5
        run_block(0, 29, -1, lat);
        chk("lat_stall", lat, 205);
        chk("mask_count_stall", mask_cnt, 160);
        chk("en2_count_stall", en2_cnt, 40);
        chk("stall_cycles", stall_cnt, 3);
        repeat (2) tick();

        // reset mid-block, then a clean block
        run_block(0, -1, 100, lat);
        chk("abort_no_done", done_cnt, 0);
        repeat (2) tick();
        run_block(0, -1, -1, lat);
        chk("lat_after_abort", lat, 202);
        chk("rc_after_abort", rc_cap[0], 6'h01);
        chk("we_after_abort", we_cnt, 40);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
